// File: rtl/zion_riscv_isa_lib_slt_pkg.sv
// Shared definitions for the set-less-than decode slice.
//   - Opcode and funct3 constants for SLT/SLTU/SLTI/SLTIU and BLT/BGE/BLTU/BGEU.
//   - SLT_RV64 / SLT_XLEN: build-wide operand width (32 or 64).
//   - slt_de_pkt_t: the decode-to-Ex packet carried through the skid buffer.
//   - Sign-extension helpers for the I- and B-immediates.
package zion_riscv_isa_lib_slt_pkg;

    localparam bit SLT_RV64 = 1'b0;
    localparam int SLT_XLEN = 32 * (int'(SLT_RV64) + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                en;
        logic                uns;
        logic [SLT_XLEN-1:0] s1;
        logic [SLT_XLEN-1:0] s2;
        logic                is_br;
        logic                inv;
        logic [4:0]          rd;
        logic [SLT_XLEN-1:0] imm;
    } slt_de_pkt_t;

    function automatic logic [SLT_XLEN-1:0] sext12(input logic [11:0] v);
        return {{(SLT_XLEN-12){v[11]}}, v};
    endfunction

    function automatic logic [SLT_XLEN-1:0] sext13(input logic [12:0] v);
        return {{(SLT_XLEN-13){v[12]}}, v};
    endfunction

endpackage

// File: rtl/zion_riscv_isa_lib_slt_decode_skid.sv
// zion_skid_buf: two-entry skid buffer with registered in_rdy/out_vld.
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              drops both entries, next state EMPTY
//   in_vld/in_rdy      upstream handshake, in_data payload
//   out_vld/out_rdy    downstream handshake, out_data payload
// The output register is the head entry; the skid register only fills when
// the head is stalled while a new packet is accepted.
module zion_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_rdy_q, out_vld_q;
    logic         in_xfer, out_xfer;

    assign in_xfer  = in_vld & in_rdy_q;
    assign out_xfer = out_vld_q & out_rdy;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            data_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        data_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        data_d = in_data;
                    end else if (in_xfer) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_rdy is low here, so only the drain side can move
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        data_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            skid_q    <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            skid_q    <= skid_d;
            in_rdy_q  <= (state_d != ST_FULL);
            out_vld_q <= (state_d != ST_EMPTY);
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_vld  = out_vld_q;
    assign out_data = data_q;

endmodule

// File: rtl/zion_riscv_isa_lib_slt_decode.sv
// zion_riscv_isa_lib_slt_decode: decode-side producer for the set-less-than
// Ex interface. Recognises SLT/SLTU/SLTI/SLTIU/BLT/BGE/BLTU/BGEU, selects
// operands and compare controls, and hands one packet per instruction to Ex
// through a two-entry skid buffer (1-cycle latency, full throughput).
//   clk, rst_n, flush            clock, async active-low reset, sync flush
//   in_vld/in_rdy, in_instr,     upstream instruction and register data
//   in_rs1, in_rs2
//   out_vld/out_rdy              Ex-side handshake
//   out_en, out_unsigned,        SltEx De fields
//   out_s1, out_s2
//   out_is_br, out_inv,          branch form, BGE-style inversion,
//   out_rd, out_imm              destination register, B-immediate
// RV64 must agree with SLT_RV64 in the package; both pick the operand width.
module zion_riscv_isa_lib_slt_decode
    import zion_riscv_isa_lib_slt_pkg::*;
#(
    parameter bit RV64 = SLT_RV64,
    localparam int CPU_WIDTH = 32 * (int'(RV64) + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [31:0]          in_instr,
    input  logic [CPU_WIDTH-1:0] in_rs1,
    input  logic [CPU_WIDTH-1:0] in_rs2,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 out_en,
    output logic                 out_unsigned,
    output logic [CPU_WIDTH-1:0] out_s1,
    output logic [CPU_WIDTH-1:0] out_s2,
    output logic                 out_is_br,
    output logic                 out_inv,
    output logic [4:0]           out_rd,
    output logic [CPU_WIDTH-1:0] out_imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    slt_de_pkt_t pkt_dec;
    slt_de_pkt_t pkt_out;
    logic        unused_rs1_field;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Register indices are resolved before register-file read; only the
    // data arrives here, so the rs1 index field has no consumer.
    assign unused_rs1_field = ^in_instr[19:15];

    // Everything defaults to zero, so unsupported encodings come out with
    // en=0 and masked operands without a separate masking stage.
    always_comb begin
        pkt_dec = '0;
        if (opcode == OPC_OP && funct7 == 7'd0 &&
            (funct3 == F3_SLT || funct3 == F3_SLTU)) begin
            pkt_dec.en  = 1'b1;
            pkt_dec.uns = funct3[0];
            pkt_dec.s1  = in_rs1;
            pkt_dec.s2  = in_rs2;
            pkt_dec.rd  = in_instr[11:7];
        end else if (opcode == OPC_OP_IMM &&
                     (funct3 == F3_SLT || funct3 == F3_SLTU)) begin
            // SLTIU compares against the sign-extended immediate as unsigned
            pkt_dec.en  = 1'b1;
            pkt_dec.uns = funct3[0];
            pkt_dec.s1  = in_rs1;
            pkt_dec.s2  = sext12(in_instr[31:20]);
            pkt_dec.rd  = in_instr[11:7];
        end else if (opcode == OPC_BRANCH && funct3[2]) begin
            // funct3[1] selects unsigned, funct3[0] the GE (inverted) forms
            pkt_dec.en    = 1'b1;
            pkt_dec.uns   = funct3[1];
            pkt_dec.inv   = funct3[0];
            pkt_dec.is_br = 1'b1;
            pkt_dec.s1    = in_rs1;
            pkt_dec.s2    = in_rs2;
            pkt_dec.imm   = sext13({in_instr[31], in_instr[7], in_instr[30:25],
                                    in_instr[11:8], 1'b0});
        end
    end

    zion_skid_buf #(
        .W($bits(slt_de_pkt_t))
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (pkt_dec),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (pkt_out)
    );

    assign out_en       = pkt_out.en;
    assign out_unsigned = pkt_out.uns;
    assign out_s1       = pkt_out.s1;
    assign out_s2       = pkt_out.s2;
    assign out_is_br    = pkt_out.is_br;
    assign out_inv      = pkt_out.inv;
    assign out_rd       = pkt_out.rd;
    assign out_imm      = pkt_out.imm;

endmodule
